// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg : shared definitions for the iterative multiply/divide unit.
//   - op encodings for mult/multu/div/divu
//   - FSM state type
//   - two's-complement negate helper
// ---------------------------------------------------------------------------
package md_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PREP = 2'b01,
      CALC = 2'b10,
      FIN  = 2'b11
   } md_state_e;

   // Working width of the negate helper; callers zero-extend into it and
   // truncate the result back, which is exact for any width up to this
   // value (so the unit supports WIDTH up to 64).
   localparam int MD_NEG_W = 130;

   function automatic logic [MD_NEG_W-1:0] md_neg(input logic [MD_NEG_W-1:0] v);
      return ~v + {{(MD_NEG_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/md_iter_unit_if.sv
// ---------------------------------------------------------------------------
// md_iter_unit_if : pipeline-side bus of the multiply/divide unit.
//   master : EX stage (drives start/op/a/b/cancel/mt*/mf*/wdata)
//   slave  : md_iter_unit (drives rdata/hi/lo/busy/done/div_zero/stall)
// ---------------------------------------------------------------------------
interface md_iter_unit_if #(parameter int WIDTH = 32);

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;
   logic             mfhi;
   logic             mflo;
   logic [WIDTH-1:0] rdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic             stall;

   modport master (
      output start, op, a, b, cancel, mthi, mtlo, wdata, mfhi, mflo,
      input  rdata, hi, lo, busy, done, div_zero, stall
   );

   modport slave (
      input  start, op, a, b, cancel, mthi, mtlo, wdata, mfhi, mflo,
      output rdata, hi, lo, busy, done, div_zero, stall
   );

endinterface

// File: rtl/md_sign_fix.sv
// ---------------------------------------------------------------------------
// md_sign_fix : combinational conditional two's-complement negate.
//   val : N-bit magnitude
//   neg : 1 = return -val, 0 = return val
//   res : N-bit result
// ---------------------------------------------------------------------------
module md_sign_fix
   import md_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] val,
   input  logic         neg,
   output logic [N-1:0] res
);

   assign res = neg ? N'(md_neg(MD_NEG_W'(val))) : val;

endmodule

// File: rtl/md_iter_unit.sv
// ---------------------------------------------------------------------------
// md_iter_unit : iterative multiply (shift-add) / divide (restoring) unit
// owning the HI/LO pair.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : start/op/a/b request, cancel flush, mthi/mtlo writes,
//                  mfhi/mflo reads on rdata, hi/lo, busy, done and div_zero
//                  pulses, stall request to the pipeline
// An operation takes WIDTH+2 cycles from start to done: one PREP cycle,
// WIDTH CALC iterations, one FIN cycle in which done is high; HI/LO are
// written on the clock edge that ends FIN.
// ---------------------------------------------------------------------------
module md_iter_unit
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clock,
   input  logic              reset,
   md_iter_unit_if.slave     bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int W2    = 2 * WIDTH;

   md_state_e        state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
   logic [W2-1:0]    acc_q, acc_d;         // {hi-part, lo-part} working register
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_lo_q, neg_lo_d;   // product / quotient sign
   logic             neg_hi_q, neg_hi_d;   // remainder sign
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;

   logic             is_div_s, is_sgn_s, a_neg_s, b_neg_s;
   logic [WIDTH-1:0] a_mag_s, b_mag_s;
   logic [WIDTH:0]   mul_sum_s, div_trial_s;
   logic [W2-1:0]    prod_fix_s;
   logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

   assign is_div_s = op_q[1];
   assign is_sgn_s = ~op_q[0];
   assign a_neg_s  = is_sgn_s & a_q[WIDTH-1];
   assign b_neg_s  = is_sgn_s & b_q[WIDTH-1];
   assign a_mag_s  = a_neg_s ? WIDTH'(md_neg(MD_NEG_W'(a_q))) : a_q;
   assign b_mag_s  = b_neg_s ? WIDTH'(md_neg(MD_NEG_W'(b_q))) : b_q;

   // One extra bit keeps the carry of the partial-product add.
   assign mul_sum_s   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
   // Trial subtract on the remainder after the left shift; msb set = negative.
   assign div_trial_s = acc_q[W2-1:WIDTH-1] - {1'b0, opnd_q};

   md_sign_fix #(.N(W2))    u_fix_prod (.val(acc_q),              .neg(neg_lo_q), .res(prod_fix_s));
   md_sign_fix #(.N(WIDTH)) u_fix_quo  (.val(acc_q[WIDTH-1:0]),   .neg(neg_lo_q), .res(quo_fix_s));
   md_sign_fix #(.N(WIDTH)) u_fix_rem  (.val(acc_q[W2-1:WIDTH]),  .neg(neg_hi_q), .res(rem_fix_s));

   // Next-state, datapath and output-pulse computation.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (bus.mthi) hi_d = bus.wdata;
            else          hi_d = hi_q;
            if (bus.mtlo) lo_d = bus.wdata;
            else          lo_d = lo_q;
            // A flush in the same cycle kills the request.
            if (bus.start && !bus.cancel) begin
               op_d    = bus.op;
               a_d     = bus.a;
               b_d     = bus.b;
               state_d = PREP;
            end else begin
               state_d = IDLE;
            end
         end
         PREP: begin
            if (bus.cancel) begin
               state_d = IDLE;
            end else begin
               opnd_d   = b_mag_s;
               acc_d    = {{WIDTH{1'b0}}, a_mag_s};
               cnt_d    = CNT_W'(WIDTH);
               neg_lo_d = a_neg_s ^ b_neg_s;
               neg_hi_d = a_neg_s;
               dz_d     = is_div_s && (b_q == {WIDTH{1'b0}});
               state_d  = dz_d ? FIN : CALC;
            end
         end
         CALC: begin
            if (bus.cancel) begin
               state_d = IDLE;
            end else begin
               if (is_div_s) begin
                  if (div_trial_s[WIDTH]) acc_d = {acc_q[W2-2:0], 1'b0};
                  else                    acc_d = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  if (acc_q[0]) acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                  else          acc_d = {1'b0, acc_q[W2-1:1]};
               end
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = (cnt_q == CNT_W'(1)) ? FIN : CALC;
            end
         end
         FIN: begin
            if (bus.cancel) begin
               state_d = IDLE;
            end else begin
               if (dz_q) begin
                  hi_d = hi_q;
                  lo_d = lo_q;
               end else if (is_div_s) begin
                  hi_d = rem_fix_s;
                  lo_d = quo_fix_s;
               end else begin
                  hi_d = prod_fix_s[W2-1:WIDTH];
                  lo_d = prod_fix_s[WIDTH-1:0];
               end
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // done/div_zero are registered so they are high for exactly the FIN cycle.
      done_d     = (state_d == FIN);
      div_zero_d = (state_d == FIN) && dz_d;
   end

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= 2'b00;
         a_q        <= {WIDTH{1'b0}};
         b_q        <= {WIDTH{1'b0}};
         opnd_q     <= {WIDTH{1'b0}};
         acc_q      <= {W2{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= {WIDTH{1'b0}};
         lo_q       <= {WIDTH{1'b0}};
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         dz_q       <= dz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.rdata    = bus.mfhi ? hi_q : lo_q;
   assign bus.stall    = (state_q != IDLE) &
                         (bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_md_iter_unit.sv
// ---------------------------------------------------------------------------
// tb_md_iter_unit : self-checking bench for md_iter_unit (WIDTH=32).
// Expected HI/LO come from plain 64-bit / 32-bit arithmetic in model_op.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_md_iter_unit;

   localparam int W = 32;

   logic clock = 1'b0;
   logic reset;

   md_iter_unit_if #(.WIDTH(W)) bus ();

   md_iter_unit #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi, m_lo;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: what HI/LO must hold after the operation, from the op's meaning.
   task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      longint      sa, sb, sp;
      logic [63:0] up;
      int          q, r;
      dz = 1'b0;
      hi = m_hi;
      lo = m_lo;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin sp = sa * sb; {hi, lo} = sp; end
         2'b01: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
         2'b10: begin
            if (b == 32'd0) dz = 1'b1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 32'd0; end
            else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               lo = q;
               hi = r;
            end
         end
         default: begin
            if (b == 32'd0) dz = 1'b1;
            else begin lo = a / b; hi = a % b; end
         end
      endcase
   endtask

   task automatic idle_inputs();
      bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0; bus.cancel = 1'b0;
      bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0; bus.mfhi = 1'b0; bus.mflo = 1'b0;
   endtask

   // Start is high during cycle 0; returns at the falling edge of cycle 1.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 100) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
      logic [31:0] eh, el;
      logic        edz;
      int          lat;
      model_op(op, a, b, eh, el, edz);
      start_op(op, a, b);
      wait_done(lat);
      check({tag, "_done_seen"}, bus.done, 1);
      if (!edz) check({tag, "_latency"}, lat, W + 2);
      else      check({tag, "_dz_latency_ok"}, (lat >= 2 && lat <= W + 2), 1);
      check({tag, "_div_zero"}, bus.div_zero, edz);
      check({tag, "_busy_in_done"}, bus.busy, 1);
      @(negedge clock);
      check({tag, "_hi"}, bus.hi, eh);
      check({tag, "_lo"}, bus.lo, el);
      check({tag, "_done_low"}, {bus.done, bus.div_zero, bus.busy}, 0);
      m_hi = eh;
      m_lo = el;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0001;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          lat, cyc;
      logic        bad_stall, bad_rd, saw_done;
      logic [31:0] eh, el, old_lo;
      logic        edz;

      idle_inputs();
      reset = 1'b1;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      repeat (2) @(negedge clock);
      check("reset_hi", bus.hi, 0);
      check("reset_lo", bus.lo, 0);
      check("reset_flags", {bus.busy, bus.done, bus.div_zero, bus.stall}, 0);
      reset = 1'b0;

      // Directed cases.
      do_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
      do_op(2'b11, 32'd7, 32'd2, "divu_7by2");

      // mthi in IDLE writes on the same edge.
      @(negedge clock);
      bus.mthi = 1'b1; bus.wdata = 32'h0000_1234;
      @(negedge clock);
      bus.mthi = 1'b0;
      check("mthi_idle", bus.hi, 32'h0000_1234);
      m_hi = 32'h0000_1234;
      do_op(2'b11, 32'd5, 32'd0, "divu_by_zero");
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");

      // start together with cancel in IDLE is ignored.
      @(negedge clock);
      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd3;
      @(negedge clock);
      bus.start = 1'b0; bus.cancel = 1'b0;
      check("start_cancel_idle", bus.busy, 0);

      // Cancel in cycle 10 of a multiply.
      start_op(2'b00, 32'd1234, 32'd5678);
      cyc = 1;
      while (cyc < 10) begin @(negedge clock); cyc++; end
      check("cancel_busy_before", bus.busy, 1);
      bus.cancel = 1'b1;
      @(negedge clock);
      bus.cancel = 1'b0;
      check("cancel_busy_drop", bus.busy, 0);
      saw_done = bus.done;
      repeat (40) begin @(negedge clock); saw_done = saw_done | bus.done; end
      check("cancel_no_done", saw_done, 0);
      check("cancel_hi_kept", bus.hi, m_hi);
      check("cancel_lo_kept", bus.lo, m_lo);

      // mtlo together with start: written now, then overwritten by the result.
      model_op(2'b01, 32'd9, 32'd11, eh, el, edz);
      @(negedge clock);
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd11;
      bus.mtlo = 1'b1; bus.wdata = 32'hCAFE_0001;
      @(negedge clock);
      bus.start = 1'b0; bus.mtlo = 1'b0;
      check("mtlo_with_start", bus.lo, 32'hCAFE_0001);
      wait_done(lat);
      check("mtlo_start_done", bus.done, 1);
      @(negedge clock);
      check("mtlo_start_result", bus.lo, el);
      m_hi = eh; m_lo = el;

      // mflo/mthi/mtlo while busy: stall held, old value visible, writes ignored.
      model_op(2'b11, 32'd100, 32'd7, eh, el, edz);
      old_lo = m_lo;
      start_op(2'b11, 32'd100, 32'd7);
      bus.mflo = 1'b1;
      bad_stall = 1'b0; bad_rd = 1'b0; lat = 1;
      while (bus.done !== 1'b1 && lat < 100) begin
         bus.mtlo = (lat == 5); bus.mthi = (lat == 5); bus.wdata = 32'hDEAD_BEEF;
         #1;
         if (bus.stall !== 1'b1) bad_stall = 1'b1;
         if (bus.rdata !== old_lo) bad_rd = 1'b1;
         @(negedge clock);
         lat++;
      end
      bus.mtlo = 1'b0; bus.mthi = 1'b0;
      #1;
      check("busy_stall_held", bad_stall, 0);
      check("busy_rdata_old", bad_rd, 0);
      check("busy_read_latency", lat, W + 2);
      check("done_cycle_stall", bus.stall, 1);
      check("done_cycle_rdata_old", bus.rdata, old_lo);
      @(negedge clock);
      #1;
      check("after_done_rdata_lo", bus.rdata, el);
      check("after_done_stall", bus.stall, 0);
      check("after_done_hi", bus.hi, eh);
      bus.mfhi = 1'b1;
      #1;
      check("after_done_rdata_hi", bus.rdata, eh);
      bus.mfhi = 1'b0; bus.mflo = 1'b0;
      m_hi = eh; m_lo = el;

      // Reset in cycle 5 of an operation clears everything at once.
      start_op(2'b00, 32'd77, 32'd3);
      cyc = 1;
      while (cyc < 5) begin @(negedge clock); cyc++; end
      bus.mflo = 1'b1;
      #1;
      check("pre_reset_stall", bus.stall, 1);
      reset = 1'b1;
      #1;
      check("midop_reset_hi", bus.hi, 0);
      check("midop_reset_lo", bus.lo, 0);
      check("midop_reset_rdata", bus.rdata, 0);
      check("midop_reset_flags", {bus.busy, bus.done, bus.div_zero, bus.stall}, 0);
      @(negedge clock);
      reset = 1'b0;
      bus.mflo = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         do_op(2'($urandom_range(0, 3)), pick(), pick(), "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
